// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: opcode constants, sequencer state encoding and opcode class helpers
package fetch_seq_pkg;
  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;
  function automatic logic is_jump(input logic [3:0] op);
    return op inside {OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP};
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op inside {OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NANDM};
  endfunction
endpackage

// File: rtl/fetch_sequencer_jump_resolve.sv
// jump_resolve: combinational branch-taken decision from opcode and registered flags
module jump_resolve
  import fetch_seq_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       cflag,
  input  logic       zflag,
  output logic       taken
);
  assign taken = instr == OP_JMP || (instr == OP_JC && cflag) || (instr == OP_JNC && !cflag) ||
                 (instr == OP_JZ && zflag) || (instr == OP_JNZ && !zflag);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch/execute FSM resolving two-byte jumps and memory ops
// Optional SEQ_HALT_EN: a taken JMP to its own first byte parks the sequencer in a halt state.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              R,
  input  logic [7:0]        program_byte,
  input  logic [3:0]        instr,
  input  logic [3:0]        operando,
  input  logic              cflag,
  input  logic              zflag,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              fetch_en,
  output logic              phase,
  output logic              exec_en,
  output logic [ADDR_W-1:0] data_addr,
  output logic              halted
);
  logic [1:0] state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, data_addr_n, target;
  logic taken, halt_hit;
  jump_resolve u_jump (.instr(instr), .cflag(cflag), .zflag(zflag), .taken(taken));
  assign pc_inc = pc + ADDR_W'(1);
  // second instruction byte arrives on program_byte while in S_EXEC
  assign target = ADDR_W'({operando, program_byte});
`ifdef SEQ_HALT_EN
  assign halt_hit = instr == OP_JMP && target == pc - ADDR_W'(1);
  assign halted = state == S_HALT;
`else
  assign halt_hit = 1'b0;
  assign halted = 1'b0;
`endif
  assign rom_addr = pc;
  assign fetch_en = state == S_FETCH;
  assign phase = state != S_FETCH;
  assign exec_en = (state == S_EXEC && !is_jump(instr) && !is_mem(instr)) || state == S_MEM;
  always_comb begin
    state_n = state;
    pc_n = pc;
    data_addr_n = data_addr;
    case (state)
      S_FETCH: begin
        pc_n = pc_inc;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = is_mem(instr) ? S_MEM : S_FETCH;
        if (is_jump(instr)) begin
          pc_n = taken ? target : pc_inc;
          state_n = taken && halt_hit ? S_HALT : S_FETCH;
        end else if (is_mem(instr)) begin
          pc_n = pc_inc;
          data_addr_n = target;
        end
      end
      S_MEM: state_n = S_FETCH;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      data_addr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      data_addr <= data_addr_n;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven instruction vectors with a scoreboard, plus multi-cycle corner sequences
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic R = 1'b1;
  logic cflag = 1'b0, zflag = 1'b0;
  logic [7:0] rom [0:4095];
  logic [7:0] fr = 8'h00, fr2 = 8'h00;
  logic [7:0] program_byte, program_byte2;
  logic [11:0] rom_addr, data_addr, rom_addr2, data_addr2;
  logic fetch_en, phase, exec_en, halted, fetch_en2, phase2, exec_en2, halted2;
  int checks = 0, failures = 0;

  typedef struct {
    logic [7:0] b0, b1;
    logic c, z;
    logic [11:0] pc;
    int cyc;
    int ex_pos;
    logic [11:0] da;
    string name;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;
  assign program_byte = rom[rom_addr];
  assign program_byte2 = rom[rom_addr2];
  always @(posedge clk) if (fetch_en) fr <= program_byte;
  always @(posedge clk) if (fetch_en2) fr2 <= program_byte2;

  fetch_sequencer dut (
    .clk(clk), .R(R), .program_byte(program_byte), .instr(fr[7:4]), .operando(fr[3:0]),
    .cflag(cflag), .zflag(zflag), .rom_addr(rom_addr), .fetch_en(fetch_en), .phase(phase),
    .exec_en(exec_en), .data_addr(data_addr), .halted(halted)
  );
  fetch_sequencer #(.ADDR_W(12), .RESET_PC(12'hFFF)) dut2 (
    .clk(clk), .R(R), .program_byte(program_byte2), .instr(fr2[7:4]), .operando(fr2[3:0]),
    .cflag(cflag), .zflag(zflag), .rom_addr(rom_addr2), .fetch_en(fetch_en2), .phase(phase2),
    .exec_en(exec_en2), .data_addr(data_addr2), .halted(halted2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [7:0] b0, input logic [7:0] b1, input logic c, input logic z,
                      input logic [11:0] pc, input int cyc, input int ex_pos, input logic [11:0] da,
                      input string name);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.c = c; v.z = z; v.pc = pc; v.cyc = cyc; v.ex_pos = ex_pos;
    v.da = da; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
  endtask

  // called at the negedge of a fetch cycle; follows one instruction up to the next fetch
  task automatic observe();
    vec_t e;
    int pos, n_ex, ex_at;
    e = sb.pop_front();
    pos = 0; n_ex = 0; ex_at = -1;
    do begin
      if (exec_en) begin
        n_ex++;
        ex_at = pos;
      end
      @(negedge clk);
      pos++;
    end while (!fetch_en && pos < 8);
    chk({e.name, "_pc"}, 32'(rom_addr), 32'(e.pc));
    chk({e.name, "_cycles"}, pos, e.cyc);
    chk({e.name, "_exec_count"}, n_ex, e.ex_pos >= 0 ? 1 : 0);
    chk({e.name, "_exec_pos"}, ex_at, e.ex_pos);
    chk({e.name, "_data_addr"}, 32'(data_addr), 32'(e.da));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int bad;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h45;
    addv(8'h45, 8'h4A, 0, 0, 12'h001, 2, 1, 12'h000, "lit");
    addv(8'h83, 8'h20, 0, 1, 12'h320, 2, -1, 12'h000, "jz_t");
    addv(8'h83, 8'h20, 0, 0, 12'h002, 2, -1, 12'h000, "jz_n");
    addv(8'h05, 8'hA7, 1, 0, 12'h5A7, 2, -1, 12'h000, "jc_t");
    addv(8'h05, 8'hA7, 0, 1, 12'h002, 2, -1, 12'h000, "jc_n");
    addv(8'h1F, 8'h01, 0, 0, 12'hF01, 2, -1, 12'h000, "jnc_t");
    addv(8'h1F, 8'h01, 1, 0, 12'h002, 2, -1, 12'h000, "jnc_n");
    addv(8'h94, 8'h56, 1, 0, 12'h456, 2, -1, 12'h000, "jnz_t");
    addv(8'h94, 8'h56, 0, 1, 12'h002, 2, -1, 12'h000, "jnz_n");
    addv(8'hC1, 8'h23, 0, 0, 12'h123, 2, -1, 12'h000, "jmp");
    addv(8'hC7, 8'h77, 1, 1, 12'h777, 2, -1, 12'h000, "jmp_flags");
    addv(8'h6A, 8'hBC, 0, 0, 12'h002, 3, 2, 12'hABC, "ld");
    addv(8'h77, 8'h11, 1, 0, 12'h002, 3, 2, 12'h711, "st");
    addv(8'h33, 8'hFE, 0, 1, 12'h002, 3, 2, 12'h3FE, "cmpm");
    addv(8'hB0, 8'h01, 0, 0, 12'h002, 3, 2, 12'h001, "addm");
    addv(8'hFF, 8'hFF, 1, 1, 12'h002, 3, 2, 12'hFFF, "nandm");
    addv(8'h29, 8'h00, 0, 0, 12'h001, 2, 1, 12'h000, "cmpi");
    addv(8'hA3, 8'h00, 1, 0, 12'h001, 2, 1, 12'h000, "addi");
    addv(8'hE1, 8'h00, 0, 1, 12'h001, 2, 1, 12'h000, "nandi");
    addv(8'h52, 8'h00, 0, 0, 12'h001, 2, 1, 12'h000, "in");
    addv(8'hD7, 8'h00, 0, 0, 12'h001, 2, 1, 12'h000, "out");

    // reset state while R is held
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(rom_addr), 32'h000);
    chk("rst_fetch_en", 32'(fetch_en), 1);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_exec_en", 32'(exec_en), 0);
    chk("rst_data_addr", 32'(data_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc2", 32'(rom_addr2), 32'hFFF);

    foreach (vecs[i]) begin
      cflag = vecs[i].c;
      zflag = vecs[i].z;
      rom[0] = vecs[i].b0;
      rom[1] = vecs[i].b1;
      do_reset();
      sb.push_back(vecs[i]);
      observe();
    end
    rom[0] = 8'h45; rom[1] = 8'h4A;
    cflag = 1'b0; zflag = 1'b0;

    // phase toggles 0,1,0,1 with pc 0,1,1,2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("phase_%0d", i), 32'(phase), i % 2);
      chk($sformatf("phase_pc_%0d", i), 32'(rom_addr), (i + 1) / 2);
      @(negedge clk);
    end

    // LD 0xABC at address 4, then data_addr holds across a one-byte op
    rom[4] = 8'h6A; rom[5] = 8'hBC;
    do_reset();
    repeat (8) @(negedge clk);
    chk("mem4_start_pc", 32'(rom_addr), 32'h004);
    v.b0 = 8'h6A; v.b1 = 8'hBC; v.c = 0; v.z = 0; v.pc = 12'h006; v.cyc = 3; v.ex_pos = 2;
    v.da = 12'hABC; v.name = "ld4";
    sb.push_back(v);
    observe();
    v.pc = 12'h007; v.cyc = 2; v.ex_pos = 1; v.name = "hold";
    sb.push_back(v);
    observe();
    rom[4] = 8'h45; rom[5] = 8'h45;

    // reset asserted inside S_MEM aborts the access at once
    rom[0] = 8'h6A; rom[1] = 8'hBC;
    do_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_mem_strobe", 32'(exec_en), 1);
    R = 1'b1;
    #1;
    chk("abort_exec_en", 32'(exec_en), 0);
    chk("abort_pc", 32'(rom_addr), 0);
    chk("abort_fetch_en", 32'(fetch_en), 1);
    chk("abort_data_addr", 32'(data_addr), 0);
    @(negedge clk);
    R = 1'b0;
    rom[0] = 8'h45; rom[1] = 8'h4A;

    // wrap from RESET_PC=0xFFF
    do_reset();
    chk("wrap_reset_pc", 32'(rom_addr2), 32'hFFF);
    @(negedge clk);
    chk("wrap_pc", 32'(rom_addr2), 32'h000);
    chk("wrap_phase", 32'(phase2), 1);
    chk("wrap_exec", 32'(exec_en2), 1);
    rom[12'hFFF] = 8'h6A; rom[0] = 8'hBC;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("wrap_ld_pc", 32'(rom_addr2), 32'h001);
    chk("wrap_ld_da", 32'(data_addr2), 32'hABC);
    chk("wrap_ld_exec", 32'(exec_en2), 1);
    rom[12'hFFF] = 8'h45; rom[0] = 8'h45;

    // self-jump at 0x010
    rom[0] = 8'hC0; rom[1] = 8'h10; rom[16] = 8'hC0; rom[17] = 8'h10;
    do_reset();
    repeat (2) @(negedge clk);
    chk("self_fetch_pc", 32'(rom_addr), 32'h010);
    chk("self_fetch_en", 32'(fetch_en), 1);
    @(negedge clk);
    chk("self_exec_pc", 32'(rom_addr), 32'h011);
    @(negedge clk);
`ifdef SEQ_HALT_EN
    chk("halt_halted", 32'(halted), 1);
    chk("halt_fetch_en", 32'(fetch_en), 0);
    chk("halt_pc", 32'(rom_addr), 32'h010);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_en || exec_en || !halted || rom_addr != 12'h010) bad++;
    end
    chk("halt_stays", bad, 0);
    do_reset();
    chk("halt_exit", 32'(halted), 0);
`else
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("loop_pc_%0d", i), 32'(rom_addr), i % 2 ? 32'h011 : 32'h010);
      if (exec_en || halted) bad++;
      @(negedge clk);
    end
    chk("loop_no_exec_halt", bad, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program-ROM read side of the CPU and the enable of the 8-bit instruction fetch register.
- Holds the 12-bit program counter and the fetch/execute phase FSM.
- Takes the decoded instr/operando nibbles plus cflag/zflag and resolves two-byte instructions (jumps, memory ops), including jump-target loading.
- Issues a one-cycle exec_en to the datapath (accumulator, flags, outputs) per executed instruction.

Parameters:
- ADDR_W, 12, program and data address width; PC and data_addr wrap modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- R  in  1  reset, asynchronous, active-high.
- program_byte  in  8  ROM data at rom_addr, valid the same cycle (combinational ROM).
- instr  in  4  opcode nibble from the fetch register.
- operando  in  4  operand nibble from the fetch register.
- cflag  in  1  registered carry flag.
- zflag  in  1  registered zero flag.
- rom_addr  out  ADDR_W  program ROM address; equals pc.
- fetch_en  out  1  enable to the fetch register's E input.
- phase  out  1  0 in the fetch cycle, 1 in all other cycles.
- exec_en  out  1  one-cycle strobe: datapath commits the current instruction.
- data_addr  out  ADDR_W  memory operand address for two-byte memory ops.
- halted  out  1  only with SEQ_HALT_EN; tied to 0 otherwise.

Behaviour:
- Reset: clk/R clocking, R async active-high. While R is high: state=S_FETCH, pc=RESET_PC, data_addr=0, halted=0. Outputs decoded from state are don't-care until R deasserts.
- Shared opcode constants:
  - JC=0000, JNC=0001, CMPI=0010, CMPM=0011, LIT=0100, IN=0101, LD=0110, ST=0111.
  - JZ=1000, JNZ=1001, ADDI=1010, ADDM=1011, JMP=1100, OUT=1101, NANDI=1110, NANDM=1111.
- Two-byte instructions:
  - Jumps: JC, JNC, JZ, JNZ, JMP.
  - Memory ops: CMPM, LD, ST, ADDM, NANDM.
  - All other opcodes are one-byte.
- S_FETCH:
  - fetch_en=1, phase=0.
  - Edge: fetch register captures program_byte; pc<=pc+1; next S_EXEC.
- S_EXEC (phase=1):
  - One-byte op: exec_en=1; next S_FETCH.
  - Jump: rom_addr=pc supplies the low address byte; target={operando, program_byte}. taken = JMP, or JC&cflag, or JNC&~cflag, or JZ&zflag, or JNZ&~zflag. pc<=taken ? target : pc+1. exec_en=0. Next S_FETCH.
  - Memory op: data_addr<={operando, program_byte}; pc<=pc+1; next S_MEM.
- S_MEM: exec_en=1, data_addr stable, phase=1; next S_FETCH.
- Timing:
  - One-byte instruction: 2 cycles.
  - Jump: 2 cycles, no exec_en.
  - Memory op: 3 cycles.
- Flags are sampled in the S_EXEC cycle. They hold values from the previous exec_en, since the flags register is enabled only on exec_en.
- pc wraps: 0xFFF+1 = 0x000, in both the fetch and the second-byte increment.
- Reset asserted mid-instruction aborts it immediately. No exec_en is issued for the aborted instruction.
- data_addr holds its value outside S_EXEC memory-op transitions.

Optional Feature:
- SEQ_HALT_EN defined:
  - A taken JMP whose target equals the address of the JMP's first byte (pc-1 at S_EXEC) enters S_HALT.
  - In S_HALT: halted=1, fetch_en=0, exec_en=0, pc frozen at target. Only R exits.
- SEQ_HALT_EN undefined: no S_HALT state; halted tied 0; a self-jump loops forever at 2 cycles per iteration.

Decomposition:
- Package fetch_seq_pkg:
  - the 16 opcode localparams;
  - state encoding (S_FETCH, S_EXEC, S_MEM, S_HALT);
  - functions is_jump(op) and is_mem(op).
- Optional sub-module jump_resolve: combinational taken decision from instr, cflag and zflag. Everything else stays in one module.

Test Plan:
- Reset/one-byte: R pulse, ROM[0]=0x45 (LIT 5), ROM[1]=0x4A → fetch_en at cycle 0, exec_en at cycle 1, pc=1, then fetch at pc=1; phase toggles 0,1,0,1.
- Conditional jump: ROM[0]=0x83, ROM[1]=0x20 (JZ 0x320). zflag=1 → pc=0x320 after 2 cycles, no exec_en. zflag=0 → pc=0x002.
- Memory op: ROM[4]=0x6A, ROM[5]=0xBC (LD 0xABC) → data_addr=0xABC, exec_en high exactly in the 3rd cycle, pc=0x006.
- Wrap: RESET_PC=0xFFF, ROM[0xFFF]=0x45 → pc=0x000 after fetch. Two-byte op at 0xFFF reads its second byte from 0x000.
- Reset in S_MEM: assert R asynchronously mid-cycle → pc=RESET_PC and state=S_FETCH immediately, no exec_en pulse.
- SEQ_HALT_EN: ROM[0x010]=0xC0, ROM[0x011]=0x10 (JMP 0x010) → halted=1 two cycles after fetch, fetch_en stays 0 for 20 cycles. Without the macro, pc alternates 0x010/0x011.
